vector_add_sub_sequencer: RTL
=============================

Name: vector_add_sub_sequencer

Overview:
Sequences one vector integer add/sub instruction (vadd/vsub/vadc/vsbc) over the 64-bit segmented adder/subtractor datapath, one 64-bit chunk per accepted beat.
- Latches the instruction configuration and walks chunk indices 0..N-1.
- Per chunk, generates byte-lane enables (tail masking against vl) and per-element carry/borrow-in bits from v0.
- Holds the configuration stable toward the carry-chain multiplexer control.
- Sits between the vector issue stage and the add/sub execution lane.

Parameters:
VLEN, 512, vector register length in bits.
DATA_WIDTH, 64, datapath width in bits; fixed at 8 byte lanes.
CHUNK_W, 3, chunk index width = log2(VLEN/DATA_WIDTH).

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset, asynchronous, active-high.
start_i  input  1  instruction request; accepted only when ready_o=1.
ready_o  output  1  sequencer idle and able to accept start_i.
add_sub_i  input  1  0=add, 1=sub.
with_carry_borrow_i  input  1  1=vadc/vsbc.
vsew_i  input  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
vl_i  input  7  active element count, 0..64.
v0_i  input  VLEN/8  mask bits: bit e = carry/borrow-in for element e.
add_sub_o  output  1  latched add_sub_i.
with_carry_borrow_o  output  1  latched with_carry_borrow_i.
vsew_o  output  2  latched vsew_i.
issue_valid_o  output  1  chunk beat valid toward datapath.
issue_ready_i  input  1  datapath/writeback accepts the beat.
chunk_idx_o  output  CHUNK_W  register chunk being processed.
byte_en_o  output  8  byte lanes holding active (body) elements.
carry_in_o  output  8  carry/borrow-in; set only at element LSB lanes.
last_o  output  1  current beat is the final chunk.
done_o  output  1  one-cycle pulse on instruction completion.

Behaviour:
- Reset (async, rst_i=1): state IDLE.
  - ready_o=1.
  - All other outputs 0.
  - Latched config, v0 copy, chunk counter cleared.
- Derived values:
  - epc = 8>>vsew (elements per chunk).
  - nchunks = ceil(vl/epc), computed from latched vl.
  - elem_base = chunk_idx*epc.
- Lane rules for lane k:
  - Element index e = elem_base + (k>>vsew).
  - byte_en_o[k] = (e < vl).
  - carry_in_o[k] = with_carry_borrow & (k mod 2^vsew == 0) & (e < vl) & v0[e]; otherwise 0.
- FSM:
  - IDLE: ready_o=1. start_i=1 latches all config and v0_i, chunk=0.
    - vl_i=0: go to DONE.
    - otherwise: go to RUN.
  - RUN: issue_valid_o=1; chunk outputs registered and stable while issue_ready_i=0.
    - Handshake, not last: chunk+1.
    - Handshake on last (chunk==nchunks-1): go to DONE.
  - DONE: done_o=1 for exactly one cycle, issue_valid_o=0, then IDLE. ready_o=0 in DONE.
- ready_o=0 in RUN and DONE; start_i there is ignored and not queued.
- Latency:
  - First beat is valid the cycle after start acceptance.
  - With no stalls, done_o asserts nchunks+1 cycles after acceptance.
- add_sub_o, with_carry_borrow_o and vsew_o:
  - Change only on start acceptance.
  - Hold through DONE and IDLE until the next start.
- Input changes other than at acceptance have no effect.
- Reset mid-RUN: immediate return to IDLE, outputs per reset values, no done_o.
- vl_i > VLEN/(8<<vsew) is clamped to that value.

Optional Feature:
- Macro: VADD_SEQ_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits).
  - Counts RUN cycles with issue_valid_o=1 and issue_ready_i=0.
  - Saturates at 0xFFFF; cleared on start acceptance and by reset.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - vsew encodings (SEW8/16/32/64).
  - Op encodings {add_sub, with_carry_borrow}.
  - FSM state typedef (IDLE/RUN/DONE).
  - Constants LANES=8 and VLEN-derived CHUNK_W.
- One natural sub-module, vsew_lane_mask_gen (combinational): takes vsew, vl, chunk_idx, with_carry_borrow and v0; produces byte_en and carry_in.

Test Plan:
- add, vsew=0, vl=13, ready held 1: 2 beats; chunk0 byte_en=0xFF, chunk1 byte_en=0x1F with last_o=1; done_o on cycle 3 after start.
- sub, vsew=2, vl=3: beats byte_en=0xFF then 0x0F; carry_in_o=0x00 on both; vsew_o=2 and add_sub_o=1 held throughout.
- vadc, vsew=1, vl=4, v0=0b1010: single beat, byte_en=0xFF, carry_in_o=0x44.
- vsew=3, vl=4, issue_ready_i low 3 cycles on chunk1: chunk_idx_o=1 and lanes stable while stalled; 4 beats total; with macro, stall_cnt_o=3.
- vl_i=0: no issue_valid_o; done_o the cycle after acceptance; ready_o back to 1 the cycle after done_o.
- rst_i asserted during chunk2 of an 8-chunk op: outputs immediately at reset values, no done_o; next start runs cleanly from chunk 0.

Source files
------------

// File: rtl/vector_add_sub_sequencer_pkg.sv
// vector_add_sub_sequencer_pkg: shared encodings, sizes and helpers for the vector add/sub sequencer
package vector_add_sub_sequencer_pkg;
  localparam int VLEN       = 512;
  localparam int DATA_WIDTH = 64;
  localparam int LANES      = DATA_WIDTH / 8;
  localparam int LANE_W     = $clog2(LANES);
  localparam int CHUNK_W    = $clog2(VLEN / DATA_WIDTH);
  localparam int NCH_W      = CHUNK_W + 1;
  localparam int MAX_ELEMS  = VLEN / 8;
  localparam int V0_W       = VLEN / 8;
  localparam int V0_IDX_W   = $clog2(V0_W);
  localparam int VL_W       = $clog2(MAX_ELEMS) + 1;

  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} vsew_e;

  // {add_sub, with_carry_borrow}
  typedef enum logic [1:0] {
    OP_VADD = 2'b00,
    OP_VADC = 2'b01,
    OP_VSUB = 2'b10,
    OP_VSBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Largest legal vl for an element width is VLEN/SEW; anything above is clamped.
  function automatic logic [VL_W-1:0] clamp_vl(logic [VL_W-1:0] vl, vsew_e sew);
    return (vl > VL_W'(MAX_ELEMS >> sew)) ? VL_W'(MAX_ELEMS >> sew) : vl;
  endfunction

  // ceil(vl / elements-per-chunk); elements-per-chunk is a power of two.
  function automatic logic [NCH_W-1:0] num_chunks(logic [VL_W-1:0] vl, vsew_e sew);
    return NCH_W'((int'(vl) + (LANES >> sew) - 1) >> (LANE_W - int'(sew)));
  endfunction
endpackage

// File: rtl/vector_add_sub_sequencer_if.sv
// vector_add_sub_sequencer_if: issue-side request and execution-lane beat signals; stall_cnt_o exists only with VADD_SEQ_STALL_COUNT_EN
interface vector_add_sub_sequencer_if;
  import vector_add_sub_sequencer_pkg::*;
  logic                start_i;
  logic                ready_o;
  logic                add_sub_i;
  logic                with_carry_borrow_i;
  logic [1:0]          vsew_i;
  logic [VL_W-1:0]     vl_i;
  logic [V0_W-1:0]     v0_i;
  logic                add_sub_o;
  logic                with_carry_borrow_o;
  logic [1:0]          vsew_o;
  logic                issue_valid_o;
  logic                issue_ready_i;
  logic [CHUNK_W-1:0]  chunk_idx_o;
  logic [LANES-1:0]    byte_en_o;
  logic [LANES-1:0]    carry_in_o;
  logic                last_o;
  logic                done_o;
`ifdef VADD_SEQ_STALL_COUNT_EN
  logic [15:0]         stall_cnt_o;
`endif

  modport master (
`ifdef VADD_SEQ_STALL_COUNT_EN
    input  stall_cnt_o,
`endif
    output start_i, add_sub_i, with_carry_borrow_i, vsew_i, vl_i, v0_i, issue_ready_i,
    input  ready_o, add_sub_o, with_carry_borrow_o, vsew_o, issue_valid_o,
           chunk_idx_o, byte_en_o, carry_in_o, last_o, done_o
  );

  modport slave (
`ifdef VADD_SEQ_STALL_COUNT_EN
    output stall_cnt_o,
`endif
    input  start_i, add_sub_i, with_carry_borrow_i, vsew_i, vl_i, v0_i, issue_ready_i,
    output ready_o, add_sub_o, with_carry_borrow_o, vsew_o, issue_valid_o,
           chunk_idx_o, byte_en_o, carry_in_o, last_o, done_o
  );
endinterface

// File: rtl/vector_add_sub_sequencer_vsew_lane_mask_gen.sv
// vsew_lane_mask_gen: per-chunk byte-lane tail enables and element-LSB carry/borrow-in bits from v0
module vsew_lane_mask_gen
  import vector_add_sub_sequencer_pkg::*;
(
  input  vsew_e              vsew,
  input  logic [VL_W-1:0]    vl,
  input  logic [CHUNK_W-1:0] chunk_idx,
  input  logic               with_carry_borrow,
  input  logic [V0_W-1:0]    v0,
  output logic [LANES-1:0]   byte_en,
  output logic [LANES-1:0]   carry_in
);
  logic [VL_W-1:0]   base;
  logic [LANE_W-1:0] sub_mask;

  // chunk_idx * (8 >> vsew) == (chunk_idx * 8) >> vsew
  assign base     = VL_W'({chunk_idx, LANE_W'(0)} >> vsew);
  assign sub_mask = LANE_W'((1 << vsew) - 1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [VL_W-1:0] e;
    assign e           = base + VL_W'(k >> vsew);
    assign byte_en[k]  = e < vl;
    assign carry_in[k] = with_carry_borrow && ((LANE_W'(k) & sub_mask) == '0) &&
                         byte_en[k] && v0[e[V0_IDX_W-1:0]];
  end
endmodule

// File: rtl/vector_add_sub_sequencer.sv
// vector_add_sub_sequencer: walks one vadd/vsub/vadc/vsbc over 64-bit chunks; optional stall counter under VADD_SEQ_STALL_COUNT_EN
module vector_add_sub_sequencer
  import vector_add_sub_sequencer_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_i,
  vector_add_sub_sequencer_if.slave bus
);
  state_e             state_q, state_d;
  op_e                op_q;
  vsew_e              vsew_q;
  logic [VL_W-1:0]    vl_q;
  logic [V0_W-1:0]    v0_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic [VL_W-1:0]    vl_clamped;
  logic [LANES-1:0]   be, ci;
  logic               accept, run, last, hs;

  assign vl_clamped = clamp_vl(bus.vl_i, vsew_e'(bus.vsew_i));
  assign accept     = (state_q == IDLE) && bus.start_i;
  assign run        = state_q == RUN;
  assign last       = {1'b0, chunk_q} == num_chunks(vl_q, vsew_q) - NCH_W'(1);
  assign hs         = run && bus.issue_ready_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;

  // next state: zero-length ops skip straight to completion
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.start_i ? ((vl_clamped == '0) ? DONE : RUN) : IDLE) :
              (state_q == RUN)  ? ((hs && last) ? DONE : RUN) : IDLE;
  end

  // instruction config is captured only at acceptance; chunk advances per non-final handshake
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      op_q    <= OP_VADD;
      vsew_q  <= SEW8;
      vl_q    <= '0;
      v0_q    <= '0;
      chunk_q <= '0;
    end else if (accept) begin
      op_q    <= op_e'({bus.add_sub_i, bus.with_carry_borrow_i});
      vsew_q  <= vsew_e'(bus.vsew_i);
      vl_q    <= vl_clamped;
      v0_q    <= bus.v0_i;
      chunk_q <= '0;
    end else if (hs && !last) begin
      chunk_q <= chunk_q + CHUNK_W'(1);
    end

  vsew_lane_mask_gen u_mask (
    .vsew              (vsew_q),
    .vl                (vl_q),
    .chunk_idx         (chunk_q),
    .with_carry_borrow (op_q[0]),
    .v0                (v0_q),
    .byte_en           (be),
    .carry_in          (ci)
  );

`ifdef VADD_SEQ_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // saturating count of beats offered but not taken
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_cnt_q <= '0;
    else if (accept) stall_cnt_q <= '0;
    else if (run && !bus.issue_ready_i && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;

  assign bus.stall_cnt_o = stall_cnt_q;
`endif

  assign bus.ready_o             = state_q == IDLE;
  assign bus.issue_valid_o       = run;
  assign bus.done_o              = state_q == DONE;
  assign bus.add_sub_o           = op_q[1];
  assign bus.with_carry_borrow_o = op_q[0];
  assign bus.vsew_o              = vsew_q;
  assign bus.chunk_idx_o         = run ? chunk_q : '0;
  assign bus.byte_en_o           = run ? be : '0;
  assign bus.carry_in_o          = run ? ci : '0;
  assign bus.last_o              = run && last;
endmodule
